// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi decoder control slice.
// Holds the default trellis geometry and the FSM state type for the
// ACS scheduler. It also holds the initial path metrics that the ACS
// units load while acs_first is high.
// No ports (package).
package viterbi_pkg;

    localparam int DEF_NUM_STATES = 64;
    localparam int DEF_NUM_ACS    = 8;
    localparam int DEF_TB_DEPTH   = 32;

    localparam int DEF_GROUPS  = DEF_NUM_STATES / DEF_NUM_ACS;
    localparam int DEF_GROUP_W = $clog2(DEF_GROUPS);
    localparam int DEF_COL_W   = $clog2(DEF_TB_DEPTH);

    // "Max" metric is half the range. A large add can then never wrap an
    // unreachable state back below a reachable one.
    localparam int METRIC_W = 10;
    localparam logic [METRIC_W-1:0] INIT_METRIC_ZERO = '0;
    localparam logic [METRIC_W-1:0] INIT_METRIC_MAX  = {1'b0, {(METRIC_W-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACS     = 2'd1,
        TB_WAIT = 2'd2
    } sched_state_e;

    // Only the encoder start state (0) begins with a zero metric.
    function automatic logic [METRIC_W-1:0] init_metric(input int unsigned state_idx);
        return (state_idx == 0) ? INIT_METRIC_ZERO : INIT_METRIC_MAX;
    endfunction

endpackage

// File: rtl/vit_col_counter.sv
// Survivor-memory column counter. Counts modulo DEPTH.
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   inc      - advance one column (wraps DEPTH-1 -> 0)
//   clr      - synchronous clear, has priority over inc
//   col      - current column
//   wrap     - high while col sits on the last column of the window
module vit_col_counter
    import viterbi_pkg::*;
#(
    parameter int DEPTH = DEF_TB_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inc,
    input  logic                     clr,
    output logic [$clog2(DEPTH)-1:0] col,
    output logic                     wrap
);

    localparam int W = $clog2(DEPTH);

    logic [W-1:0] col_q;
    logic [W-1:0] col_d;

    // DEPTH is a power of two, so the plain increment wraps by itself.
    always_comb begin
        col_d = col_q;
        if (clr) begin
            col_d = '0;
        end else if (inc) begin
            col_d = col_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
        end else begin
            col_q <= col_d;
        end
    end

    assign col  = col_q;
    assign wrap = (col_q == W'(DEPTH - 1));

endmodule

// File: rtl/viterbi_acs_sched.sv
// Control sequencer for the rate-1/2 Viterbi decoder.
// Accepts one received symbol pair at a time. It then runs NUM_ACS-wide
// ACS units over all trellis states in GROUPS consecutive cycles. After
// each step it flips the metric bank and advances the survivor column.
// It launches a traceback when a window fills and at frame end.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   in_valid/in_ready    - symbol pair handshake
//   rx_pair, frame_last  - received {g1,g0} and end-of-frame qualifier
//   rx_pair_q            - registered pair broadcast to the BMC units
//   acs_en, acs_group    - ACS update strobe and state group index
//   acs_first            - ACS units use initial metrics this step
//   bank_sel             - metric bank read this step
//   wr_col               - survivor column written this step
//   tb_start/final/col   - traceback launch, frame-end flag, last column
//   tb_done              - traceback unit finished
//   frame_done           - pulse after the frame-end traceback completes
module viterbi_acs_sched
    import viterbi_pkg::*;
#(
    parameter int NUM_STATES = DEF_NUM_STATES,
    parameter int NUM_ACS    = DEF_NUM_ACS,
    parameter int TB_DEPTH   = DEF_TB_DEPTH
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [1:0]                            rx_pair,
    input  logic                                  frame_last,
    output logic [1:0]                            rx_pair_q,
    output logic                                  acs_en,
    output logic [$clog2(NUM_STATES/NUM_ACS)-1:0] acs_group,
    output logic                                  acs_first,
    output logic                                  bank_sel,
    output logic [$clog2(TB_DEPTH)-1:0]           wr_col,
    output logic                                  tb_start,
    output logic                                  tb_final,
    output logic [$clog2(TB_DEPTH)-1:0]           tb_col,
    input  logic                                  tb_done,
    output logic                                  frame_done
);

    localparam int GROUPS  = NUM_STATES / NUM_ACS;
    localparam int GROUP_W = $clog2(GROUPS);
    localparam int COL_W   = $clog2(TB_DEPTH);

    sched_state_e       state_q, state_d;
    logic [GROUP_W-1:0] group_q, group_d;
    logic [1:0]         rx_pair_d;
    logic               last_q, last_d;
    logic               bank_sel_q, bank_sel_d;
    logic               acs_first_q, acs_first_d;
    logic               tb_start_q, tb_start_d;
    logic               tb_final_q, tb_final_d;
    logic [COL_W-1:0]   tb_col_q, tb_col_d;
    logic               frame_done_q, frame_done_d;

    logic col_inc;
    logic col_clr;
    logic col_wrap;
    logic last_grp;
    logic tb_trig;
    logic handshake;

    vit_col_counter #(
        .DEPTH (TB_DEPTH)
    ) u_col (
        .clk  (clk),
        .rst  (rst),
        .inc  (col_inc),
        .clr  (col_clr),
        .col  (wr_col),
        .wrap (col_wrap)
    );

    // A step ends on its last group. A traceback is due if the window
    // is full or the frame ends. Both can be true together; that still
    // gives one launch, flagged as the frame-end traceback.
    assign last_grp  = (state_q == ACS) && (group_q == GROUP_W'(GROUPS - 1));
    assign tb_trig   = last_grp && (last_q || col_wrap);
    assign handshake = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            group_q      <= '0;
            rx_pair_q    <= '0;
            last_q       <= 1'b0;
            bank_sel_q   <= 1'b0;
            acs_first_q  <= 1'b1;
            tb_start_q   <= 1'b0;
            tb_final_q   <= 1'b0;
            tb_col_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            group_q      <= group_d;
            rx_pair_q    <= rx_pair_d;
            last_q       <= last_d;
            bank_sel_q   <= bank_sel_d;
            acs_first_q  <= acs_first_d;
            tb_start_q   <= tb_start_d;
            tb_final_q   <= tb_final_d;
            tb_col_q     <= tb_col_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        group_d      = group_q;
        rx_pair_d    = rx_pair_q;
        last_d       = last_q;
        bank_sel_d   = bank_sel_q;
        acs_first_d  = acs_first_q;
        tb_start_d   = 1'b0;
        tb_final_d   = 1'b0;
        tb_col_d     = '0;
        frame_done_d = 1'b0;
        col_inc      = 1'b0;
        col_clr      = 1'b0;

        // A pair is only accepted in IDLE or on a step's last group.
        // So rx_pair_q and the last flag never change mid-step.
        if (handshake) begin
            rx_pair_d = rx_pair;
            last_d    = frame_last;
        end

        case (state_q)
            IDLE: begin
                if (handshake) begin
                    state_d = ACS;
                    group_d = '0;
                end
            end
            ACS: begin
                if (!last_grp) begin
                    group_d = group_q + 1'b1;
                end else begin
                    group_d     = '0;
                    bank_sel_d  = ~bank_sel_q;
                    acs_first_d = 1'b0;
                    col_inc     = 1'b1;
                    if (tb_trig) begin
                        // Capture the column before it advances. Traceback
                        // starts from the column just written.
                        state_d    = TB_WAIT;
                        tb_start_d = 1'b1;
                        tb_final_d = last_q;
                        tb_col_d   = wr_col;
                    end else if (!handshake) begin
                        state_d = IDLE;
                    end
                end
            end
            TB_WAIT: begin
                // tb_done is ignored on the launch cycle itself.
                if (tb_done && !tb_start_q) begin
                    state_d = IDLE;
                    if (last_q) begin
                        frame_done_d = 1'b1;
                        col_clr      = 1'b1;
                        bank_sel_d   = 1'b0;
                        acs_first_d  = 1'b1;
                        last_d       = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        acs_en   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            ACS: begin
                acs_en   = 1'b1;
                in_ready = last_grp && !tb_trig;
            end
            default: begin
                in_ready = 1'b0;
                acs_en   = 1'b0;
            end
        endcase
    end

    assign acs_group  = group_q;
    assign acs_first  = acs_first_q;
    assign bank_sel   = bank_sel_q;
    assign tb_start   = tb_start_q;
    assign tb_final   = tb_final_q;
    assign tb_col     = tb_col_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_viterbi_acs_sched.sv
// Self-checking bench for viterbi_acs_sched (default geometry: 8 groups,
// 32-column windows).
module tb_viterbi_acs_sched;

    localparam int G = 8;
    localparam int D = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] rx_pair = 2'b00;
    logic       frame_last = 1'b0;
    logic [1:0] rx_pair_q;
    logic       acs_en;
    logic [2:0] acs_group;
    logic       acs_first;
    logic       bank_sel;
    logic [4:0] wr_col;
    logic       tb_start;
    logic       tb_final;
    logic [4:0] tb_col;
    logic       tb_done = 1'b0;
    logic       frame_done;

    int checks = 0;
    int errors = 0;
    int tbStartCount = 0;

    viterbi_acs_sched dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rx_pair    (rx_pair),
        .frame_last (frame_last),
        .rx_pair_q  (rx_pair_q),
        .acs_en     (acs_en),
        .acs_group  (acs_group),
        .acs_first  (acs_first),
        .bank_sel   (bank_sel),
        .wr_col     (wr_col),
        .tb_start   (tb_start),
        .tb_final   (tb_final),
        .tb_col     (tb_col),
        .tb_done    (tb_done),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Running count of traceback launches, used to prove "exactly one".
    always @(negedge clk) begin
        if (tb_start === 1'b1) tbStartCount++;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time expired, required completion");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct packed {
        logic       iv;
        logic [1:0] ip;
        logic       il;
        logic       itd;
        logic       eRdy;
        logic       eEn;
        logic [2:0] eGrp;
        logic       eFirst;
        logic       eBank;
        logic [4:0] eCol;
        logic       eTbs;
        logic       eTbf;
        logic [4:0] eTbc;
        logic       eFd;
        logic [1:0] eRxq;
    } vec_t;

    vec_t tbl [15];
    logic [1:0] pairs [5] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b10};

    // Behavioural model state: integer step bookkeeping per frame.
    int         mPhase;
    int         mPos;
    int         mSteps;
    int         mTbCol;
    logic [1:0] mPair;
    logic       mLast;
    logic       mTbPulse;
    logic       mTbFinal;
    logic       mFd;

    function automatic vec_t mkVec(input logic iv, input logic [1:0] ip, input logic il,
                                   input logic itd, input logic eRdy, input logic eEn,
                                   input logic [2:0] eGrp, input logic eFirst, input logic eBank,
                                   input logic [4:0] eCol, input logic eTbs, input logic eTbf,
                                   input logic [4:0] eTbc, input logic eFd, input logic [1:0] eRxq);
        vec_t v;
        v = '{iv, ip, il, itd, eRdy, eEn, eGrp, eFirst, eBank, eCol, eTbs, eTbf, eTbc, eFd, eRxq};
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] p, input logic l, input logic d);
        in_valid   = v;
        rx_pair    = p;
        frame_last = l;
        tb_done    = d;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic resetDut();
        rst = 1'b1;
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic modelReset();
        mPhase   = 0;
        mPos     = 0;
        mSteps   = 0;
        mTbCol   = 0;
        mPair    = 2'b00;
        mLast    = 1'b0;
        mTbPulse = 1'b0;
        mTbFinal = 1'b0;
        mFd      = 1'b0;
    endtask

    // Offers one pair and waits (bounded) for acceptance. Returns at the
    // cycle after the handshake, i.e. group 0 of the new step.
    task automatic sendSymbol(input logic [1:0] p, input logic l);
        int waitCnt;
        waitCnt = 0;
        applyStimulus(1'b1, p, l, 1'b0);
        @(negedge clk);
        while (in_ready !== 1'b1 && waitCnt < 200) begin
            tick();
            @(negedge clk);
            waitCnt++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL handshake_timeout: in_ready=%0b, required 1", in_ready);
        end
        tick();
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    initial begin
        int tbBase;
        $display("[TB] viterbi_acs_sched bench starting");

        // Single-symbol frame, with spurious tb_done in IDLE (c0) and ACS (c4).
        tbl[0] = mkVec(1, 2'b10, 1, 1, 1, 0, 3'd0, 1, 0, 5'd0, 0, 0, 5'd0, 0, 2'b00);
        for (int i = 1; i <= 8; i++) begin
            tbl[i] = mkVec(0, 2'b00, 0, (i == 4), 0, 1, 3'(i - 1), 1, 0, 5'd0, 0, 0, 5'd0, 0, 2'b10);
        end
        tbl[9]  = mkVec(0, 2'b00, 0, 0, 0, 0, 3'd0, 0, 1, 5'd1, 1, 1, 5'd0, 0, 2'b10);
        tbl[10] = mkVec(0, 2'b00, 0, 0, 0, 0, 3'd0, 0, 1, 5'd1, 0, 0, 5'd0, 0, 2'b10);
        tbl[11] = mkVec(0, 2'b00, 0, 0, 0, 0, 3'd0, 0, 1, 5'd1, 0, 0, 5'd0, 0, 2'b10);
        tbl[12] = mkVec(0, 2'b00, 0, 1, 0, 0, 3'd0, 0, 1, 5'd1, 0, 0, 5'd0, 0, 2'b10);
        tbl[13] = mkVec(0, 2'b00, 0, 0, 1, 0, 3'd0, 1, 0, 5'd0, 0, 0, 5'd0, 1, 2'b10);
        tbl[14] = mkVec(0, 2'b00, 0, 0, 1, 0, 3'd0, 1, 0, 5'd0, 0, 0, 5'd0, 0, 2'b10);

        // Reset state.
        resetDut();
        @(negedge clk);
        checkOutput("rst_in_ready",   32'(in_ready),   32'd1);
        checkOutput("rst_acs_en",     32'(acs_en),     32'd0);
        checkOutput("rst_acs_group",  32'(acs_group),  32'd0);
        checkOutput("rst_acs_first",  32'(acs_first),  32'd1);
        checkOutput("rst_bank_sel",   32'(bank_sel),   32'd0);
        checkOutput("rst_wr_col",     32'(wr_col),     32'd0);
        checkOutput("rst_tb_start",   32'(tb_start),   32'd0);
        checkOutput("rst_tb_final",   32'(tb_final),   32'd0);
        checkOutput("rst_tb_col",     32'(tb_col),     32'd0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
        checkOutput("rst_rx_pair_q",  32'(rx_pair_q),  32'd0);
        tick();

        // Table-driven single-symbol frame.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(tbl[i].iv, tbl[i].ip, tbl[i].il, tbl[i].itd);
            @(negedge clk);
            checkOutput("tbl_in_ready",   32'(in_ready),   32'(tbl[i].eRdy));
            checkOutput("tbl_acs_en",     32'(acs_en),     32'(tbl[i].eEn));
            checkOutput("tbl_acs_group",  32'(acs_group),  32'(tbl[i].eGrp));
            checkOutput("tbl_acs_first",  32'(acs_first),  32'(tbl[i].eFirst));
            checkOutput("tbl_bank_sel",   32'(bank_sel),   32'(tbl[i].eBank));
            checkOutput("tbl_wr_col",     32'(wr_col),     32'(tbl[i].eCol));
            checkOutput("tbl_tb_start",   32'(tb_start),   32'(tbl[i].eTbs));
            checkOutput("tbl_frame_done", 32'(frame_done), 32'(tbl[i].eFd));
            checkOutput("tbl_rx_pair_q",  32'(rx_pair_q),  32'(tbl[i].eRxq));
            if (tbl[i].eTbs) begin
                checkOutput("tbl_tb_final", 32'(tb_final), 32'(tbl[i].eTbf));
                checkOutput("tbl_tb_col",   32'(tb_col),   32'(tbl[i].eTbc));
            end
            tick();
        end
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);

        // Back-to-back stream of five pairs with in_valid held high.
        resetDut();
        for (int c = 0; c <= 41; c++) begin
            applyStimulus(c <= 32, (c <= 32) ? pairs[c / 8] : 2'b00, 1'b0, 1'b0);
            @(negedge clk);
            if (c <= 40) checkOutput("b2b_in_ready", 32'(in_ready), 32'(c % 8 == 0));
            if (c >= 1 && c <= 40) begin
                checkOutput("b2b_acs_en",    32'(acs_en),    32'd1);
                checkOutput("b2b_acs_group", 32'(acs_group), 32'((c - 1) % 8));
                checkOutput("b2b_wr_col",    32'(wr_col),    32'((c - 1) / 8));
                checkOutput("b2b_bank_sel",  32'(bank_sel),  32'(((c - 1) / 8) % 2));
                checkOutput("b2b_rx_pair_q", 32'(rx_pair_q), 32'(pairs[(c - 1) / 8]));
            end
            if (c == 41) begin
                checkOutput("b2b_idle_acs_en", 32'(acs_en),   32'd0);
                checkOutput("b2b_idle_ready",  32'(in_ready), 32'd1);
            end
            tick();
        end

        // Window traceback after 32 non-last symbols.
        resetDut();
        tbBase = tbStartCount;
        for (int k = 0; k < 32; k++) sendSymbol(2'(k), 1'b0);
        @(negedge clk);
        checkOutput("win_col31",      32'(wr_col),                32'd31);
        checkOutput("win_no_early_tb", 32'(tbStartCount - tbBase), 32'd0);
        repeat (8) tick();
        @(negedge clk);
        checkOutput("win_tb_start", 32'(tb_start), 32'd1);
        checkOutput("win_tb_final", 32'(tb_final), 32'd0);
        checkOutput("win_tb_col",   32'(tb_col),   32'd31);
        checkOutput("win_in_ready", 32'(in_ready), 32'd0);
        checkOutput("win_acs_en",   32'(acs_en),   32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            checkOutput("win_wait_ready", 32'(in_ready), 32'd0);
            checkOutput("win_wait_tbs",   32'(tb_start), 32'd0);
        end
        tick();
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("win_resume_ready", 32'(in_ready),   32'd1);
        checkOutput("win_no_frame_done", 32'(frame_done), 32'd0);
        tick();
        sendSymbol(2'b11, 1'b0);
        @(negedge clk);
        checkOutput("win_next_en",    32'(acs_en),    32'd1);
        checkOutput("win_next_col",   32'(wr_col),    32'd0);
        checkOutput("win_next_first", 32'(acs_first), 32'd0);
        checkOutput("win_next_bank",  32'(bank_sel),  32'd0);
        checkOutput("win_next_rxq",   32'(rx_pair_q), 32'd3);
        tick();

        // Frame end coinciding with the window boundary.
        resetDut();
        tbBase = tbStartCount;
        for (int k = 0; k < 32; k++) sendSymbol(2'(k + 1), k == 31);
        repeat (8) tick();
        @(negedge clk);
        checkOutput("bnd_tb_start", 32'(tb_start), 32'd1);
        checkOutput("bnd_tb_final", 32'(tb_final), 32'd1);
        checkOutput("bnd_tb_col",   32'(tb_col),   32'd31);
        repeat (3) tick();
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("bnd_frame_done", 32'(frame_done),             32'd1);
        checkOutput("bnd_acs_first",  32'(acs_first),              32'd1);
        checkOutput("bnd_wr_col",     32'(wr_col),                 32'd0);
        checkOutput("bnd_bank_sel",   32'(bank_sel),               32'd0);
        checkOutput("bnd_tb_once",    32'(tbStartCount - tbBase),  32'd1);
        tick();

        // Reset in the middle of the second step (group 4).
        resetDut();
        sendSymbol(2'b01, 1'b0);
        sendSymbol(2'b11, 1'b0);
        repeat (4) tick();
        @(negedge clk);
        checkOutput("mid_pre_group", 32'(acs_group), 32'd4);
        checkOutput("mid_pre_col",   32'(wr_col),    32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mid_acs_en",    32'(acs_en),    32'd0);
        checkOutput("mid_in_ready",  32'(in_ready),  32'd1);
        checkOutput("mid_wr_col",    32'(wr_col),    32'd0);
        checkOutput("mid_bank_sel",  32'(bank_sel),  32'd0);
        checkOutput("mid_acs_first", 32'(acs_first), 32'd1);
        checkOutput("mid_rx_pair_q", 32'(rx_pair_q), 32'd0);
        tick();

        // Randomised traffic against the behavioural model.
        resetDut();
        modelReset();
        for (int c = 0; c < 4000; c++) begin
            logic        eRdy, trig, hs, doRst, vIn, lIn, dIn, nPulse, nFd;
            logic [1:0]  pIn;
            logic [21:0] expV, actV;
            int          col;

            trig = (mPhase == 1) && (mPos == G - 1) && (mLast || (mSteps % D) == D - 1);
            eRdy = (mPhase == 0) || ((mPhase == 1) && (mPos == G - 1) && !trig);
            doRst = ($urandom_range(0, 299) == 0);
            vIn   = ($urandom_range(0, 3) != 0);
            pIn   = 2'($urandom_range(0, 3));
            lIn   = ($urandom_range(0, 19) == 0);
            if (mTbPulse)        dIn = 1'b0;
            else if (mPhase == 2) dIn = ($urandom_range(0, 2) == 0);
            else                 dIn = ($urandom_range(0, 7) == 0);
            rst = doRst;
            applyStimulus(vIn, pIn, lIn, dIn);
            @(negedge clk);

            expV = {eRdy, 1'(mPhase == 1), (mPhase == 1) ? 3'(mPos) : 3'd0, 1'(mSteps == 0),
                    1'(mSteps % 2), 5'(mSteps % D), mTbPulse, mTbPulse ? mTbFinal : 1'b0,
                    mTbPulse ? 5'(mTbCol) : 5'd0, mFd, mPair};
            actV = {in_ready, acs_en, acs_group, acs_first, bank_sel, wr_col, tb_start,
                    mTbPulse ? tb_final : 1'b0, mTbPulse ? tb_col : 5'd0, frame_done, rx_pair_q};
            checkOutput("rand_cycle", 32'(actV), 32'(expV));

            hs     = vIn && eRdy;
            nPulse = 1'b0;
            nFd    = 1'b0;
            if (doRst) begin
                modelReset();
            end else begin
                if (mPhase == 0) begin
                    if (hs) begin
                        mPhase = 1; mPos = 0; mPair = pIn; mLast = lIn;
                    end
                end else if (mPhase == 1) begin
                    if (mPos < G - 1) begin
                        mPos++;
                    end else begin
                        col = mSteps % D;
                        mSteps++;
                        mPos = 0;
                        if (trig) begin
                            mPhase = 2; nPulse = 1'b1; mTbCol = col; mTbFinal = mLast;
                        end else if (hs) begin
                            mPair = pIn; mLast = lIn;
                        end else begin
                            mPhase = 0;
                        end
                    end
                end else begin
                    if (dIn && !mTbPulse) begin
                        mPhase = 0;
                        if (mLast) begin
                            nFd = 1'b1; mSteps = 0; mLast = 1'b0;
                        end
                    end
                end
                mTbPulse = nPulse;
                mFd      = nFd;
            end
            tick();
        end
        rst = 1'b0;
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
